// File: rtl/lemonpc_pkg.sv
// Shared LemonPC core constants and types for the integer register file.
// Optional feature used by register_file_sb: REGFILE_BYPASS_EN.
package lemonpc_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int XLEN            = 32;
    localparam int NR_READ_DEFAULT = 2;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush drops all.
// busy_cnt tracks the popcount of the busy bits incrementally.
module regfile_scoreboard
    import lemonpc_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_WIDTH-1:0]    rd,
    input  logic                     issue_en,
    input  logic [ADDR_WIDTH-1:0]    issue_rd,
    input  logic                     flush,
    output logic [2**ADDR_WIDTH-1:0] busy,
    output logic [ADDR_WIDTH:0]      busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] busy_next;
    logic             issue_valid;
    logic             write_valid;
    logic             rise;
    logic             fall;

    assign issue_valid = issue_en && (issue_rd != '0);
    assign write_valid = wen && (rd != '0);

    // Later statements win: issue overrides writeback clear, flush overrides both.
    always_comb begin
        busy_next = busy;
        if (write_valid)
            busy_next[rd] = 1'b0;
        if (issue_valid)
            busy_next[issue_rd] = 1'b1;
        if (flush)
            busy_next = '0;
        busy_next[0] = 1'b0;
    end

    // Count edges on the bit level so the counter never needs a popcount tree.
    assign rise = issue_valid && !busy[issue_rd];
    assign fall = write_valid && busy[rd] && !(issue_valid && (issue_rd == rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (flush)
                busy_cnt <= '0;
            else
                busy_cnt <= busy_cnt + {{ADDR_WIDTH{1'b0}}, rise}
                                     - {{ADDR_WIDTH{1'b0}}, fall};
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Integer register file with NR_READ combinational read ports, x0 hardwired to zero
// and a busy scoreboard. Define REGFILE_BYPASS_EN for writeback-to-read forwarding.
module register_file_sb
    import lemonpc_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN,
    parameter int NR_READ    = NR_READ_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NR_READ*ADDR_WIDTH-1:0] rs_addr,
    output logic [NR_READ*DATA_WIDTH-1:0] rs_data,
    output logic [NR_READ-1:0]            rs_busy,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         rd,
    input  logic [DATA_WIDTH-1:0]         dataD,
    input  logic                          issue_en,
    input  logic [ADDR_WIDTH-1:0]         issue_rd,
    input  logic                          flush,
    output logic [ADDR_WIDTH:0]           busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy;

    regfile_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .rd       (rd),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                rf[i] <= '0;
        end else if (wen && (rd != '0)) begin
            rf[rd] <= dataD;
        end
    end

    for (genvar g = 0; g < NR_READ; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign addr = rs_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

        // Reads are forced to zero while reset is held, and x0 never reads busy.
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (!rst && (addr != '0)) begin
                data = rf[addr];
                bsy  = busy[addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (!rst && wen && (rd != '0) && (rd == addr)) begin
                data = dataD;
                bsy  = 1'b0;
            end
`endif
        end

        assign rs_data[g*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rs_busy[g]                          = bsy;
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (default parameters).
// Bypass expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rs_addr = '0;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wen = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] dataD = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        flush = 1'b0;
    logic [5:0]  busy_cnt;

    int check_count = 0;
    int pass_count  = 0;

    register_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wen      (wen),
        .rd       (rd),
        .dataD    (dataD),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    // Drives one cycle of control inputs across a rising edge, then returns to idle.
    task automatic applyStimulus(input logic w, input logic [4:0] w_rd,
                                 input logic [31:0] w_data, input logic iss,
                                 input logic [4:0] iss_rd, input logic fl);
        wen      = w;
        rd       = w_rd;
        dataD    = w_data;
        issue_en = iss;
        issue_rd = iss_rd;
        flush    = fl;
        @(posedge clk);
        #1;
        wen      = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
        #1;
    endtask

    task automatic setRead(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
        #1;
    endtask

    initial begin
        // Reset held: every port reads zero.
        setRead(5'd0, 5'd0);
        checkOutput("reset_data", rs_data, 64'h0);
        checkOutput("reset_busy", {62'h0, rs_busy}, 64'h0);
        checkOutput("reset_cnt", {58'h0, busy_cnt}, 64'h0);
        #9;
        rst = 1'b0;

        // Mid-run reset wipes data and scoreboard.
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b1, 5'd3, 1'b0);
        setRead(5'd5, 5'd3);
        checkOutput("x5_written", {32'h0, rs_data[31:0]}, 64'h1234);
        checkOutput("x3_busy_pre_reset", {62'h0, rs_busy}, 64'h2);
        rst = 1'b1;
        #1;
        checkOutput("reset_held_read", rs_data, 64'h0);
        checkOutput("reset_held_busy", {62'h0, rs_busy}, 64'h0);
        #12;
        rst = 1'b0;
        #1;
        checkOutput("x5_after_reset", {32'h0, rs_data[31:0]}, 64'h0);
        checkOutput("busy_after_reset", {62'h0, rs_busy}, 64'h0);
        checkOutput("cnt_after_reset", {58'h0, busy_cnt}, 64'h0);

        // Plain write/read and the hardwired x0.
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        setRead(5'd0, 5'd7);
        checkOutput("x7_port1", {32'h0, rs_data[63:32]}, 64'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
        checkOutput("x0_port0", {32'h0, rs_data[31:0]}, 64'h0);
        checkOutput("x0_busy", {63'h0, rs_busy[0]}, 64'h0);

        // Scoreboard lifecycle, including a redundant re-issue.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        setRead(5'd3, 5'd0);
        checkOutput("x3_issue_busy", {63'h0, rs_busy[0]}, 64'h1);
        checkOutput("x3_issue_cnt", {58'h0, busy_cnt}, 64'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        checkOutput("x3_reissue_cnt", {58'h0, busy_cnt}, 64'h1);
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0);
        checkOutput("x3_wb_busy", {63'h0, rs_busy[0]}, 64'h0);
        checkOutput("x3_wb_cnt", {58'h0, busy_cnt}, 64'h0);
        checkOutput("x3_wb_data", {32'h0, rs_data[31:0]}, 64'h33);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        checkOutput("x0_issue_cnt", {58'h0, busy_cnt}, 64'h0);

        // Same-cycle issue and writeback: set wins, data still lands.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        applyStimulus(1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 1'b0);
        setRead(5'd4, 5'd6);
        checkOutput("x4_set_wins_busy", {63'h0, rs_busy[0]}, 64'h1);
        checkOutput("x4_set_wins_data", {32'h0, rs_data[31:0]}, 64'hAAAA);
        checkOutput("x4_set_wins_cnt", {58'h0, busy_cnt}, 64'h2);
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 1'b0);
        setRead(5'd5, 5'd6);
        checkOutput("rise_fall_cnt", {58'h0, busy_cnt}, 64'h2);
        checkOutput("rise_fall_busy", {62'h0, rs_busy}, 64'h1);

        // Flush clears everything and suppresses a same-cycle issue.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        checkOutput("flush1_cnt", {58'h0, busy_cnt}, 64'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        setRead(5'd9, 5'd1);
        checkOutput("three_busy_cnt", {58'h0, busy_cnt}, 64'h3);
        checkOutput("three_busy_ports", {62'h0, rs_busy}, 64'h3);
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 1'b1);
        checkOutput("flush2_cnt", {58'h0, busy_cnt}, 64'h0);
        checkOutput("flush2_ports", {62'h0, rs_busy}, 64'h0);
        checkOutput("flush2_write_lands", {32'h0, rs_data[63:32]}, 64'h11);
        setRead(5'd10, 5'd2);
        checkOutput("flush2_x10_x2", {62'h0, rs_busy}, 64'h0);

        // Writeback in the same cycle as a read of that register.
        applyStimulus(1'b1, 5'd8, 32'h22, 1'b1, 5'd8, 1'b0);
        setRead(5'd8, 5'd0);
        checkOutput("x8_pre_busy", {63'h0, rs_busy[0]}, 64'h1);
        wen   = 1'b1;
        rd    = 5'd8;
        dataD = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_data", {32'h0, rs_data[31:0]}, 64'h55);
        checkOutput("bypass_busy", {63'h0, rs_busy[0]}, 64'h0);
`else
        checkOutput("nobypass_data", {32'h0, rs_data[31:0]}, 64'h22);
        checkOutput("nobypass_busy", {63'h0, rs_busy[0]}, 64'h1);
`endif
        @(posedge clk);
        #1;
        wen = 1'b0;
        #1;
        checkOutput("x8_after_data", {32'h0, rs_data[31:0]}, 64'h55);
        checkOutput("x8_after_busy", {63'h0, rs_busy[0]}, 64'h0);
        checkOutput("x8_after_cnt", {58'h0, busy_cnt}, 64'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
